// File: rtl/pipe_mux_nx1.sv
// rtl/pipe_mux_nx1.sv - N:1 selector with one registered output stage and valid/ready flow control
// Out-of-range selects load DEFAULT and raise sel_err; accepted transfers are counted modulo 2^16.
module pipe_mux_nx1 #(
   parameter int               WIDTH   = 16,
   parameter int               N       = 4,
   parameter int               SEL_W   = 2,
   parameter logic [WIDTH-1:0] DEFAULT = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [SEL_W-1:0]     sel,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_W-1:0]     out_sel,
   output logic                 sel_err,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [15:0]          xfer_cnt
);

   generate
      if (N < 2 || N > (1 << SEL_W)) begin : g_bad_params
         $error("pipe_mux_nx1: N must be in 2..2**SEL_W");
      end
   endgenerate

   // One extra bit so N == 2**SEL_W is representable in the range compare.
   localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state;
   logic             accept;
   logic             drain;
   logic             sel_oor;
   logic [WIDTH-1:0] pick;

   assign out_valid = (state == FULL);
   assign in_ready  = (state == EMPTY) | out_ready;
   assign accept    = in_valid & in_ready;
   assign drain     = (state == FULL) & out_ready;
   assign sel_oor   = ({1'b0, sel} >= N_LIM);

   always_comb begin
      pick = DEFAULT;
      for (int k = 0; k < N; k++) begin
         if (sel == SEL_W'(k)) begin
            pick = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= EMPTY;
         out_data <= '0;
         out_sel  <= '0;
         sel_err  <= 1'b0;
         xfer_cnt <= 16'h0000;
      end else begin
         if (accept) begin
            state    <= FULL;
            out_data <= pick;
            out_sel  <= sel;
            sel_err  <= sel_oor;
            xfer_cnt <= xfer_cnt + 16'h0001;
         end else if (drain) begin
            // Payload registers keep their last values once the entry leaves.
            state <= EMPTY;
         end
      end
   end

endmodule

// File: tb/tb_pipe_mux_nx1.sv
// tb/tb_pipe_mux_nx1.sv - scoreboard bench for pipe_mux_nx1 (N=4 and N=3 instances)
// Shared stimulus drives both instances; each has its own expected-entry queue and counter model.
module tb_pipe_mux_nx1;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] in_data;
   logic [1:0]  sel;
   logic        in_valid;
   logic        out_ready;

   logic        ir[2];
   logic [15:0] od[2];
   logic [1:0]  os[2];
   logic        er[2];
   logic        ov[2];
   logic [15:0] cnt[2];

   int errors = 0;
   int checks = 0;

   logic [18:0] q0[$];
   logic [18:0] q1[$];
   int          mcnt[2];
   logic        stalled[2];
   logic [18:0] held[2];

   always #5 clk = ~clk;

   pipe_mux_nx1 #(.WIDTH(16), .N(4), .SEL_W(2), .DEFAULT(16'h0000)) u4 (
      .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .in_valid(in_valid),
      .in_ready(ir[0]), .out_data(od[0]), .out_sel(os[0]), .sel_err(er[0]),
      .out_valid(ov[0]), .out_ready(out_ready), .xfer_cnt(cnt[0])
   );

   pipe_mux_nx1 #(.WIDTH(16), .N(3), .SEL_W(2), .DEFAULT(16'hDEAD)) u3 (
      .clk(clk), .reset(reset), .in_data(in_data[47:0]), .sel(sel), .in_valid(in_valid),
      .in_ready(ir[1]), .out_data(od[1]), .out_sel(os[1]), .sel_err(er[1]),
      .out_valid(ov[1]), .out_ready(out_ready), .xfer_cnt(cnt[1])
   );

   task automatic check(input string name, input int d, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
      end
   endtask

   // Reference: pick channel s if it exists in an n-channel selector, else the default word.
   function automatic logic [18:0] ref_entry(input int n, input logic [15:0] dflt,
                                             input logic [63:0] d, input logic [1:0] s);
      logic [15:0] ch[4];
      for (int i = 0; i < 4; i++) ch[i] = d[i*16 +: 16];
      if (int'(s) < n) return {1'b0, s, ch[s]};
      return {1'b1, s, dflt};
   endfunction

   // Stimulus side of the scoreboard: predict each accepted transfer and the counter.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            if (d == 0) q0.delete(); else q1.delete();
            mcnt[d] = 0;
         end else begin
            check("xfer_cnt", d, int'(cnt[d]), mcnt[d]);
            check("in_ready", d, int'(ir[d]), int'(!ov[d] || out_ready));
            if (in_valid && ir[d]) begin
               if (d == 0) q0.push_back(ref_entry(4, 16'h0000, in_data, sel));
               else        q1.push_back(ref_entry(3, 16'hDEAD, in_data, sel));
               mcnt[d] = (mcnt[d] + 1) % 65536;
            end
         end
      end
   end

   // Monitor: compare every drained entry and verify stalled outputs stay put.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         logic [18:0] cur;
         logic [18:0] exp;
         int          qs;
         if (reset) begin
            stalled[d] = 1'b0;
         end else begin
            cur = {er[d], os[d], od[d]};
            if (stalled[d]) check("stall_hold", d, int'(cur), int'(held[d]));
            if (ov[d] && out_ready) begin
               qs = (d == 0) ? q0.size() : q1.size();
               if (qs == 0) begin
                  check("unexpected_out", d, 1, 0);
               end else begin
                  exp = (d == 0) ? q0.pop_front() : q1.pop_front();
                  check("out_entry", d, int'(cur), int'(exp));
               end
            end
            stalled[d] = ov[d] && !out_ready;
            held[d]    = cur;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      sel       = 2'd0;
      in_data   = 64'h4444_3333_2222_1111;
      stalled[0] = 1'b0;
      stalled[1] = 1'b0;

      // 1: reset held two cycles with in_valid high
      tick();
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      for (int d = 0; d < 2; d++) begin
         check("rst_out_valid", d, int'(ov[d]), 0);
         check("rst_out_data", d, int'(od[d]), 0);
         check("rst_xfer_cnt", d, int'(cnt[d]), 0);
         check("rst_in_ready", d, int'(ir[d]), 1);
      end

      // 2: select sweep, back-to-back
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         tick();
         check("sweep_data", 0, int'(od[0]), (s + 1) * 16'h1111);
         check("sweep_valid", 0, int'(ov[0]), 1);
      end
      in_valid = 1'b0;
      check("sweep_cnt", 0, int'(cnt[0]), 4);
      check("sweep_cnt", 1, int'(cnt[1]), 4);
      tick();

      // 3: backpressure with changing inputs
      out_ready = 1'b0;
      in_valid  = 1'b1;
      sel       = 2'd2;
      tick();
      for (int i = 0; i < 3; i++) begin
         in_data = {$urandom, $urandom};
         sel     = 2'($urandom_range(0, 3));
         check("bp_data", 0, int'(od[0]), 16'h3333);
         check("bp_in_ready", 0, int'(ir[0]), 0);
         tick();
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      tick();
      check("bp_release_valid", 0, int'(ov[0]), 0);
      check("bp_release_data", 0, int'(od[0]), 16'h3333);

      // 4: out-of-range select on the 3-channel instance
      in_data  = 64'h4444_3333_2222_1111;
      in_valid = 1'b1;
      sel      = 2'd3;
      tick();
      check("oor_data", 1, int'(od[1]), 16'hDEAD);
      check("oor_err", 1, int'(er[1]), 1);
      check("oor_sel", 1, int'(os[1]), 3);
      sel = 2'd1;
      tick();
      check("oor_next_err", 1, int'(er[1]), 0);
      check("oor_next_data", 1, int'(od[1]), 16'h2222);

      // 6: drain and accept in the same cycle
      in_data = 64'hDDDD_CCCC_BBBB_AAAA;
      sel     = 2'd0;
      tick();
      sel = 2'd1;
      tick();
      check("simul_valid", 0, int'(ov[0]), 1);
      check("simul_data", 0, int'(od[0]), 16'hBBBB);
      in_valid = 1'b0;
      tick();

      // Randomized traffic against the scoreboard
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         sel       = 2'($urandom_range(0, 3));
         in_data   = {$urandom, $urandom};
         tick();
      end

      // 5: counter wrap, then reset while stalled full
      reset    = 1'b1;
      in_valid = 1'b0;
      tick();
      reset     = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         sel = 2'(i);
         tick();
      end
      check("wrap_pre", 0, int'(cnt[0]), 16'hFFFF);
      tick();
      check("wrap_zero", 0, int'(cnt[0]), 0);
      check("wrap_zero", 1, int'(cnt[1]), 0);
      out_ready = 1'b0;
      tick();
      check("stall_full", 0, int'(ov[0]), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         check("midrst_valid", d, int'(ov[d]), 0);
         check("midrst_cnt", d, int'(cnt[d]), 0);
      end

      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      check("queue_drained", 0, q0.size(), 0);
      check("queue_drained", 1, q1.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
